// File: rtl/demux_id_q.sv
// Instruction queue between fetch and decode: DEPTH-entry valid/ready FIFO of {isc, pc}
// with the head entry decoded combinationally into MIPS fields, real_op and an extended immediate.
module demux_id_q #(
  parameter int ISC_W  = 32,
  parameter int ADR_W  = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1,
  parameter int XIMM_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ISC_W-1:0]  isc_in,
  input  logic [ADR_W-1:0]  pc_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        op,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        rfunct,
  output logic [15:0]       imm,
  output logic [ADR_W-1:0]  addr,
  output logic [5:0]        real_op,
  output logic [XIMM_W-1:0] imm_x,
  output logic [ADR_W-1:0]  pc_next,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ISC_W-1:0] isc_mem_q [DEPTH];
  logic [ADR_W-1:0] pc_mem_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic push, pop;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is reset explicitly; flush only moves pointers and leaves data in place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        isc_mem_q[i] <= '0;
        pc_mem_q[i]  <= '0;
      end
    end else if (push && !flush) begin
      isc_mem_q[wr_ptr_q] <= isc_in;
      pc_mem_q[wr_ptr_q]  <= pc_in;
    end
  end

  // Head entry gated by out_valid so an empty or flushed queue presents all-zero fields.
  logic [ISC_W-1:0] head_isc;
  logic [31:0]      lui_val;

  assign head_isc = out_valid ? isc_mem_q[rd_ptr_q] : '0;
  assign pc_next  = out_valid ? pc_mem_q[rd_ptr_q]  : '0;

  assign op      = head_isc[31:26];
  assign rs      = head_isc[25:21];
  assign rt      = head_isc[20:16];
  assign rd      = head_isc[15:11];
  assign shamt   = head_isc[10:6];
  assign rfunct  = head_isc[5:0];
  assign imm     = head_isc[15:0];
  assign addr    = ADR_W'(head_isc[15:0]);
  assign real_op = (op == 6'h00) ? rfunct : op;
  assign lui_val = {head_isc[15:0], 16'h0000};

  always_comb begin
    imm_x = XIMM_W'($signed(imm));
    unique case (op)
      6'h0C, 6'h0D, 6'h0E: imm_x = XIMM_W'(imm);
      6'h0F:               imm_x = XIMM_W'(lui_val);
      default:             imm_x = XIMM_W'($signed(imm));
    endcase
  end

endmodule

// File: tb/tb_demux_id_q.sv
// Directed bench for demux_id_q: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_demux_id_q;

  localparam int ISC_W  = 32;
  localparam int ADR_W  = 16;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
  localparam int XIMM_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [ISC_W-1:0]  isc_in = '0;
  logic [ADR_W-1:0]  pc_in = '0;
  logic              in_ready, out_valid;
  logic [5:0]        op, rfunct, real_op;
  logic [4:0]        rs, rt, rd, shamt;
  logic [15:0]       imm;
  logic [ADR_W-1:0]  addr, pc_next;
  logic [XIMM_W-1:0] imm_x;
  logic [CNT_W-1:0]  count;

  demux_id_q #(.ISC_W(ISC_W), .ADR_W(ADR_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .XIMM_W(XIMM_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .isc_in(isc_in), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .rfunct(rfunct),
    .imm(imm), .addr(addr), .real_op(real_op), .imm_x(imm_x),
    .pc_next(pc_next), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of {isc, pc}
  typedef struct packed {
    logic [31:0] isc;
    logic [15:0] pc;
  } entry_t;

  entry_t mq[$];

  always @(posedge clk or negedge rst) begin
    bit do_push, do_pop;
    if (!rst) begin
      mq.delete();
    end else begin
      do_push = in_valid && (mq.size() < DEPTH);
      do_pop  = out_ready && (mq.size() > 0);
      if (flush) begin
        mq.delete();
      end else begin
        if (do_pop)  void'(mq.pop_front());
        if (do_push) mq.push_back('{isc: isc_in, pc: pc_in});
      end
    end
  end

  // Compare process: all outputs vs. model, half a cycle after each active edge
  always @(negedge clk) begin
    logic [31:0] e_isc;
    logic [15:0] e_pc, e_imm;
    logic [5:0]  e_op, e_fn, e_rop;
    logic [31:0] e_x;
    if (rst && cmp_en) begin
      e_isc = (mq.size() > 0) ? mq[0].isc : 32'h0;
      e_pc  = (mq.size() > 0) ? mq[0].pc  : 16'h0;
      e_op  = 6'(e_isc >> 26);
      e_fn  = 6'(e_isc);
      e_imm = 16'(e_isc);
      e_rop = (e_op == 0) ? e_fn : e_op;
      if (e_op == 6'h0C || e_op == 6'h0D || e_op == 6'h0E) e_x = {16'h0, e_imm};
      else if (e_op == 6'h0F)                              e_x = {e_imm, 16'h0};
      else                                                 e_x = {{16{e_imm[15]}}, e_imm};
      check("m_count",     count,     64'(mq.size()));
      check("m_out_valid", out_valid, 64'(mq.size() != 0));
      check("m_in_ready",  in_ready,  64'(mq.size() != DEPTH));
      check("m_fields", {op, rs, rt, rd, shamt, rfunct},
            {e_op, 5'(e_isc >> 21), 5'(e_isc >> 16), 5'(e_isc >> 11), 5'(e_isc >> 6), e_fn});
      check("m_imm",     {imm, addr}, {e_imm, e_imm});
      check("m_real_op", real_op, e_rop);
      check("m_imm_x",   imm_x,   e_x);
      check("m_pc_next", pc_next, e_pc);
    end
  end

  task automatic step(input bit v, input logic [31:0] i, input logic [15:0] p,
                      input bit r, input bit f);
    in_valid  = v;
    isc_in    = i;
    pc_in     = p;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_count",     count,     0);
    check("rst_fields",    {op, rs, imm, real_op, pc_next}, 0);
    rst = 1'b1;
    cmp_en = 1'b1;
    step(0, 0, 0, 0, 0);

    // Single push: add $8,$9,$10
    step(1, 32'h012A4020, 16'h0004, 0, 0);
    check("add_valid",  out_valid, 1);
    check("add_fields", {op, rs, rt, rd, rfunct}, {6'h00, 5'd9, 5'd10, 5'd8, 6'h20});
    check("add_real_op", real_op, 6'h20);
    check("add_pc",      pc_next, 16'h0004);
    check("add_count",   count,   1);
    step(0, 0, 0, 1, 0);
    check("add_drained", count, 0);

    // Fill to DEPTH, reject a fifth word, then drain in order
    for (int k = 0; k < 4; k++) step(1, 32'h0000_0020 + 32'(k), 16'h0010 + 16'(k), 0, 0);
    check("full_count", count, 4);
    check("full_ready", in_ready, 0);
    step(1, 32'hDEADBEEF, 16'h0099, 0, 0);
    check("full_reject_count", count, 4);
    for (int k = 0; k < 4; k++) begin
      check("drain_order_pc", pc_next, 16'h0010 + 16'(k));
      step(0, 0, 0, 1, 0);
    end
    check("drain_empty", out_valid, 0);

    // Immediate extension; these entries wrap the pointers past DEPTH
    step(1, 32'h3C08FFFF, 16'h0040, 0, 0);
    step(1, 32'h3508FFFF, 16'h0044, 0, 0);
    step(1, 32'h2108FFFF, 16'h0048, 0, 0);
    check("lui_imm_x", imm_x, 32'hFFFF0000);
    check("lui_rop",   real_op, 6'h0F);
    step(0, 0, 0, 1, 0);
    check("ori_imm_x", imm_x, 32'h0000FFFF);
    check("ori_rop",   real_op, 6'h0D);
    step(0, 0, 0, 1, 0);
    check("addi_imm_x", imm_x, 32'hFFFFFFFF);
    check("addi_rop",   real_op, 6'h08);
    step(0, 0, 0, 1, 0);

    // Flush at count=3 with simultaneous push and pop
    for (int k = 0; k < 3; k++) step(1, 32'h0100_0000 + 32'(k), 16'h0050 + 16'(k), 0, 0);
    check("pre_flush_count", count, 3);
    step(1, 32'hCAFEF00D, 16'h0077, 1, 1);
    check("flush_count", count, 0);
    check("flush_valid", out_valid, 0);
    check("flush_ready", in_ready, 1);
    check("flush_pc",    pc_next, 0);
    step(0, 0, 0, 1, 0);
    check("flush_discard", {out_valid, pc_next}, 0);

    // Simultaneous push and pop at count=1
    step(1, 32'h20010005, 16'h0030, 0, 0);
    step(1, 32'h8C220008, 16'h0034, 1, 0);
    check("pp_count", count, 1);
    check("pp_pc",    pc_next, 16'h0034);
    check("pp_op",    op, 6'h23);
    step(1, 32'h00000000, 16'h0038, 0, 0);
    check("stall_pc",    pc_next, 16'h0034);
    check("stall_count", count, 2);

    // Asynchronous reset between clock edges
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_count", count, 0);
    check("arst_ready", in_ready, 1);
    check("arst_out",   {op, imm_x, pc_next}, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    step(1, 32'h012A4020, 16'h0060, 0, 0);
    check("post_rst_pc", pc_next, 16'h0060);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
